// File: rtl/cla_multiword_sequencer.sv
// -----------------------------------------------------------------------------
// cla_multiword_sequencer
//   Performs a 16*WORDS-bit addition on one shared 16-bit carry-lookahead
//   adder (cla_16bit). One 16-bit slice is added per clock, least significant
//   slice first. The carry between slices is kept in a register and fed back
//   as the adder's carry-in.
//
//   Optional feature macro: CLA_MULTIWORD_SUB_EN
//     When defined, an extra input `sub` selects subtraction (a - b). B is
//     inverted on capture and the initial carry is forced to 1.
//
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  asynchronous active-high reset
//   start in  1  request, accepted only while ready=1
//   a     in  N  operand A, sampled on accept
//   b     in  N  operand B, sampled on accept
//   cin   in  1  carry-in to slice 0, sampled on accept
//   sub   in  1  (CLA_MULTIWORD_SUB_EN only) subtract select, sampled on accept
//   ready out 1  high only while idle
//   busy  out 1  high while running and in the done cycle
//   done  out 1  one-cycle pulse, sum/cout valid
//   sum   out N  registered result
//   cout  out 1  registered carry-out of the most significant slice
// -----------------------------------------------------------------------------

// 16-bit two-level carry-lookahead adder: four 4-bit groups whose group
// generate/propagate terms feed a second lookahead level.
module cla_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_c0,
  output logic [15:0] o_s,
  output logic        o_c16
);
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Second-level lookahead: carries into each group straight from C0.
  assign w_gc[0] = i_c0;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & i_c0);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_c0);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_c0);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_c0);

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;
    assign w_gg[k] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                   | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_gp[k] = &w_p[B+3:B];
    // First-level lookahead inside the group, from the group carry-in.
    assign w_c[B]   = w_gc[k];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[k]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);
  end

  assign o_s   = w_p ^ w_c;
  assign o_c16 = w_gc[4];
endmodule

module cla_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
`ifdef CLA_MULTIWORD_SUB_EN
  input  logic                sub,
`endif
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                cout
);
  localparam int N    = 16 * WORDS;
  localparam int IDXW = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [15:0]       r_a     [WORDS];
  logic [15:0]       r_b     [WORDS];
  logic [15:0]       r_acc   [WORDS];
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [N-1:0]      r_sum;
  logic              r_cout;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic [15:0]       w_s;
  logic              w_c16;

  // Single shared slice adder; operands come from the selected slice.
  cla_16bit u_cla (
    .i_a   (r_a[r_idx]),
    .i_b   (r_b[r_idx]),
    .i_c0  (r_carry),
    .o_s   (w_s),
    .o_c16 (w_c16)
  );

  // Control FSM with slice datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= {IDXW{1'b0}};
      r_carry <= 1'b0;
      r_sum   <= {N{1'b0}};
      r_cout  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        r_a[i]   <= 16'h0000;
        r_b[i]   <= 16'h0000;
        r_acc[i] <= 16'h0000;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < WORDS; i++) begin
              r_a[i] <= a[16*i +: 16];
`ifdef CLA_MULTIWORD_SUB_EN
              r_b[i] <= sub ? ~b[16*i +: 16] : b[16*i +: 16];
`else
              r_b[i] <= b[16*i +: 16];
`endif
            end
`ifdef CLA_MULTIWORD_SUB_EN
            // Two's-complement subtract: a + ~b + 1.
            r_carry <= sub ? 1'b1 : cin;
`else
            r_carry <= cin;
`endif
            r_idx   <= {IDXW{1'b0}};
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc[r_idx] <= w_s;
          r_carry      <= w_c16;
          if (r_idx == IDXW'(WORDS - 1)) begin
            // The last slice bypasses the accumulator so sum is valid with done.
            for (int i = 0; i < WORDS - 1; i++) begin
              r_sum[16*i +: 16] <= r_acc[i];
            end
            r_sum[N-1 -: 16] <= w_s;
            r_cout  <= w_c16;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_idx   <= {IDXW{1'b0}};
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_idx   <= {IDXW{1'b0}};
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;
endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Self-checking bench for cla_multiword_sequencer (WORDS=4). Expected results
// come from plain 65-bit arithmetic on the operands.
module tb_cla_multiword_sequencer;
  localparam int WORDS = 4;
  localparam int N     = 16 * WORDS;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
`ifdef CLA_MULTIWORD_SUB_EN
  logic         sub;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int n_chk;
  int n_err;
  logic [N-1:0] prev_sum;
  logic         prev_cout;

  cla_multiword_sequencer #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CLA_MULTIWORD_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: plain op, 1: second start pulsed during RUN, 2: reset in 2nd RUN cycle
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tbv,
                       input logic tcin, input logic tsub, input int mode);
    logic [N:0] full;
    logic       eff_sub;
    int         done_seen;
    eff_sub = tsub;
`ifndef CLA_MULTIWORD_SUB_EN
    eff_sub = 1'b0;
`endif
    if (eff_sub) full = {1'b0, ta} + {1'b0, ~tbv} + 65'd1;
    else         full = {1'b0, ta} + {1'b0, tbv} + {64'd0, tcin};

    @(negedge clk);
    check_eq("ready_before_start", ready, 1'b1);
    a = ta; b = tbv; cin = tcin;
`ifdef CLA_MULTIWORD_SUB_EN
    sub = tsub;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
    check_eq("busy_after_accept", busy, 1'b1);
    check_eq("ready_after_accept", ready, 1'b0);

    for (int k = 1; k <= WORDS; k++) begin
      if (mode == 2 && k == 2) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_sum", sum, 65'd0);
        check_eq("abort_cout", cout, 1'b0);
        check_eq("abort_ready", ready, 1'b1);
        check_eq("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int j = 0; j < 8; j++) begin
          @(posedge clk); #1;
          if (done === 1'b1) done_seen++;
        end
        check_eq("abort_no_done", done_seen, 65'd0);
        check_eq("abort_idle_ready", ready, 1'b1);
        prev_sum  = '0;
        prev_cout = 1'b0;
        return;
      end
      if (mode == 1 && k == 2) begin
        @(negedge clk);
        start = 1'b1; a = '1; b = '1; cin = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (k < WORDS) begin
        check_eq("run_done_low", done, 1'b0);
        check_eq("run_busy", busy, 1'b1);
        check_eq("run_sum_hold", sum, prev_sum);
        check_eq("run_cout_hold", cout, prev_cout);
      end else begin
        check_eq("done_pulse", done, 1'b1);
        check_eq("done_sum", sum, full[N-1:0]);
        check_eq("done_cout", cout, full[N]);
        check_eq("done_busy", busy, 1'b1);
        check_eq("done_ready", ready, 1'b0);
      end
    end
    @(posedge clk); #1;
    check_eq("post_done_low", done, 1'b0);
    check_eq("post_ready", ready, 1'b1);
    check_eq("post_busy", busy, 1'b0);
    check_eq("post_sum_hold", sum, full[N-1:0]);
    prev_sum  = full[N-1:0];
    prev_cout = full[N];
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    prev_sum = '0; prev_cout = 1'b0;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef CLA_MULTIWORD_SUB_EN
    sub = 1'b0;
`endif
    #2 rst = 1'b1;
    #1;
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_sum", sum, 65'd0);
    check_eq("rst_cout", cout, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
    do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 0);
    do_op(64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b0, 1'b0, 1);
    do_op(64'hDEAD_BEEF_0000_1111, 64'h1, 1'b1, 1'b0, 2);
    do_op(64'h3, 64'h4, 1'b0, 1'b0, 0);

    for (int r = 0; r < 25; r++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (r % 5 == 0) ra = '1;
      do_op(ra, rb, 1'($urandom), 1'($urandom), 0);
    end

`ifdef CLA_MULTIWORD_SUB_EN
    do_op(64'h5, 64'h7, 1'b0, 1'b1, 0);
    do_op(64'h7, 64'h5, 1'b0, 1'b1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
